sext_narrow: RTL

SEXT_NARROW -- requirements
Module: sext_narrow

---
 rtl/sext_narrow_if.sv | 26 ++
 rtl/sext_narrow.sv | 81 ++++++++
 2 files changed

// File: rtl/sext_narrow_if.sv
// Request/result bundle for sext_narrow: one input handshake, one output handshake.
interface sext_narrow_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    in_width;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_field;
    logic             out_fits;
    logic [CW-1:0]    out_minw;

    modport master (
        output in_valid, in_data, in_width, out_ready,
        input  in_ready, out_valid, out_field, out_fits, out_minw
    );

    modport slave (
        input  in_valid, in_data, in_width, out_ready,
        output in_ready, out_valid, out_field, out_fits, out_minw
    );
endinterface

// File: rtl/sext_narrow.sv
// Narrows a captured word to a (width code + 1)-bit field, reporting the minimal
// sign-extension width found by a one-bit-per-cycle scan from the MSB downward.
module sext_narrow #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    sext_narrow_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES   = '1;
    localparam logic [CW-1:0]    TOP    = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ONE_CW = CW'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    width_q;
    logic [CW-1:0]    c_q;
    logic [WIDTH-1:0] field_q;
    logic             fits_q;
    logic [CW-1:0]    minw_q;

    logic             hit;
    logic [WIDTH-1:0] mask;

    // At c==0 the index wraps to the MSB; harmless because c==0 already ends the scan.
    always_comb begin
        hit  = (c_q == '0) || (data_q[c_q - ONE_CW] != data_q[WIDTH-1]);
        mask = ONES >> (TOP - width_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_next = SCAN;
            SCAN:    if (hit)           state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            width_q <= '0;
            c_q     <= '0;
            field_q <= '0;
            fits_q  <= 1'b0;
            minw_q  <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                data_q  <= bus.in_data;
                width_q <= bus.in_width;
                c_q     <= TOP;
            end else if (state == SCAN) begin
                if (hit) begin
                    field_q <= data_q & mask;
                    fits_q  <= (c_q <= width_q);
                    minw_q  <= c_q;
                end else begin
                    c_q <= c_q - ONE_CW;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_field = field_q;
    assign bus.out_fits  = fits_q;
    assign bus.out_minw  = minw_q;
endmodule
